// File: rtl/response_collector.sv
// Response collector: FWFT buffer for hash-table responses, re-emitted to the host
// as PACKET_LEN-word packets with early close on flush, plus saturating status counters.
module response_collector #(
  parameter int RESP_WIDTH = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int PACKET_LEN = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [RESP_WIDTH-1:0]         data_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  output logic [RESP_WIDTH-1:0]         m_data_o,
  output logic                          m_valid_o,
  output logic                          m_last_o,
  input  logic                          m_ready_i,
  input  logic                          flush_i,
  input  logic                          clear_stats_i,
  output logic [CNT_WIDTH-1:0]          cnt_total_o,
  output logic [CNT_WIDTH-1:0]          cnt_key_present_o,
  output logic [CNT_WIDTH-1:0]          cnt_not_found_o,
  output logic [CNT_WIDTH-1:0]          cnt_no_space_o,
  output logic [CNT_WIDTH-1:0]          cnt_no_del_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int PW = (PACKET_LEN > 1) ? $clog2(PACKET_LEN) : 1;
  localparam logic [PW-1:0] PKT_MAX = PW'(PACKET_LEN - 1);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  logic [RESP_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wptr;
  logic [AW-1:0]         r_rptr;
  logic [LW-1:0]         r_level;
  logic [PW-1:0]         r_pkt;
  logic [0:0]            r_state;
  logic [CNT_WIDTH-1:0]  r_cnt_total;
  logic [CNT_WIDTH-1:0]  r_cnt_key;
  logic [CNT_WIDTH-1:0]  r_cnt_nf;
  logic [CNT_WIDTH-1:0]  r_cnt_ns;
  logic [CNT_WIDTH-1:0]  r_cnt_nd;

  logic                  w_in_acc;
  logic                  w_out_acc;
  logic [LW-1:0]         w_level_nxt;

  function automatic logic [CNT_WIDTH-1:0] stat_next(
    input logic [CNT_WIDTH-1:0] cur,
    input logic                 clr,
    input logic                 hit
  );
    logic [CNT_WIDTH-1:0] base;
    base = clr ? '0 : cur;
    if (hit && (base != '1))
      base = base + CNT_WIDTH'(1);
    return base;
  endfunction

  assign ready_o   = (r_state == ST_RUN) && (r_level < LW'(FIFO_DEPTH));
  assign m_valid_o = (r_level != '0);
  assign m_data_o  = r_mem[r_rptr];
  assign m_last_o  = m_valid_o &&
                     ((r_pkt == PKT_MAX) || ((r_state == ST_DRAIN) && (r_level == LW'(1))));

  assign w_in_acc  = valid_i && ready_o;
  assign w_out_acc = m_valid_o && m_ready_i;

  always_comb begin
    w_level_nxt = r_level;
    if (w_in_acc && !w_out_acc)
      w_level_nxt = r_level + LW'(1);
    else if (!w_in_acc && w_out_acc)
      w_level_nxt = r_level - LW'(1);
  end

  // Storage carries no reset; occupancy and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_in_acc)
      r_mem[r_wptr] <= data_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_in_acc)
        r_wptr <= r_wptr + AW'(1);
      if (w_out_acc)
        r_rptr <= r_rptr + AW'(1);
      r_level <= w_level_nxt;
    end
  end

  // A flush that would leave the FIFO empty closes the packet without entering DRAIN,
  // so DRAIN always has a word left to carry the closing m_last_o.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_RUN;
      r_pkt   <= '0;
    end else begin
      if (w_out_acc)
        r_pkt <= m_last_o ? '0 : r_pkt + PW'(1);
      case (r_state)
        ST_RUN: begin
          if (flush_i) begin
            if (w_level_nxt != '0)
              r_state <= ST_DRAIN;
            else
              r_pkt <= '0;
          end
        end
        default: begin
          if (w_out_acc && (r_level == LW'(1)))
            r_state <= ST_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt_total <= '0;
      r_cnt_key   <= '0;
      r_cnt_nf    <= '0;
      r_cnt_ns    <= '0;
      r_cnt_nd    <= '0;
    end else begin
      r_cnt_total <= stat_next(r_cnt_total, clear_stats_i, w_in_acc);
      r_cnt_key   <= stat_next(r_cnt_key,   clear_stats_i, w_in_acc && data_i[31]);
      r_cnt_nf    <= stat_next(r_cnt_nf,    clear_stats_i, w_in_acc && data_i[30]);
      r_cnt_ns    <= stat_next(r_cnt_ns,    clear_stats_i, w_in_acc && data_i[29]);
      r_cnt_nd    <= stat_next(r_cnt_nd,    clear_stats_i, w_in_acc && data_i[28]);
    end
  end

  assign cnt_total_o       = r_cnt_total;
  assign cnt_key_present_o = r_cnt_key;
  assign cnt_not_found_o   = r_cnt_nf;
  assign cnt_no_space_o    = r_cnt_ns;
  assign cnt_no_del_o      = r_cnt_nd;
  assign fifo_level_o      = r_level;

endmodule

// File: tb/tb_response_collector.sv
// Scoreboard bench for response_collector: words queued on in-accept, popped and
// compared at the host port, with a packet/drain/counter reference model.
module tb_response_collector;
  localparam int RW = 32;
  localparam int FD = 16;
  localparam int PL = 8;
  localparam int CW = 4;
  localparam int LW = $clog2(FD) + 1;

  logic          clk;
  logic          reset;
  logic [RW-1:0] data_i;
  logic          valid_i;
  logic          ready_o;
  logic [RW-1:0] m_data_o;
  logic          m_valid_o;
  logic          m_last_o;
  logic          m_ready_i;
  logic          flush_i;
  logic          clear_stats_i;
  logic [CW-1:0] cnt_total_o;
  logic [CW-1:0] cnt_key_present_o;
  logic [CW-1:0] cnt_not_found_o;
  logic [CW-1:0] cnt_no_space_o;
  logic [CW-1:0] cnt_no_del_o;
  logic [LW-1:0] fifo_level_o;

  response_collector #(
    .RESP_WIDTH(RW), .FIFO_DEPTH(FD), .PACKET_LEN(PL), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset), .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
    .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_last_o(m_last_o), .m_ready_i(m_ready_i),
    .flush_i(flush_i), .clear_stats_i(clear_stats_i),
    .cnt_total_o(cnt_total_o), .cnt_key_present_o(cnt_key_present_o),
    .cnt_not_found_o(cnt_not_found_o), .cnt_no_space_o(cnt_no_space_o),
    .cnt_no_del_o(cnt_no_del_o), .fifo_level_o(fifo_level_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [RW-1:0] sb_q[$];
  int            m_pkt;
  bit            m_drain;
  int            m_cnt[5];
  int            out_idx;
  logic [31:0]   last_mask;
  bit            in_acc_seen;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // One clock: sample/check at the falling edge, update the model, return after the rising edge.
  task automatic cyc();
    bit in_acc, out_acc, exp_last, drain0;
    @(negedge clk);
    in_acc_seen = 0;
    if (reset) begin
      sb_q.delete();
      m_pkt = 0;
      m_drain = 0;
      for (int i = 0; i < 5; i++) m_cnt[i] = 0;
    end else begin
      drain0   = m_drain;
      exp_last = (sb_q.size() != 0) &&
                 ((m_pkt == PL - 1) || (m_drain && sb_q.size() == 1));
      check("level",   64'(fifo_level_o), 64'(sb_q.size()));
      check("m_valid", 64'(m_valid_o), 64'(sb_q.size() != 0));
      check("ready",   64'(ready_o), 64'(!m_drain && sb_q.size() < FD));
      check("m_last",  64'(m_last_o), 64'(exp_last));
      if (sb_q.size() != 0) check("m_data", 64'(m_data_o), 64'(sb_q[0]));
      check("cnt_total", 64'(cnt_total_o),       64'(m_cnt[0]));
      check("cnt_key",   64'(cnt_key_present_o), 64'(m_cnt[1]));
      check("cnt_nf",    64'(cnt_not_found_o),   64'(m_cnt[2]));
      check("cnt_ns",    64'(cnt_no_space_o),    64'(m_cnt[3]));
      check("cnt_nd",    64'(cnt_no_del_o),      64'(m_cnt[4]));

      in_acc  = valid_i && !m_drain && (sb_q.size() < FD);
      out_acc = (sb_q.size() != 0) && m_ready_i;
      if (out_acc) begin
        if (m_last_o && out_idx < 32) last_mask[out_idx] = 1'b1;
        out_idx++;
        if (exp_last) begin
          if (m_drain && sb_q.size() == 1) m_drain = 0;
          m_pkt = 0;
        end else begin
          m_pkt++;
        end
        void'(sb_q.pop_front());
      end
      if (in_acc) sb_q.push_back(data_i);
      if (flush_i && !drain0) begin
        if (sb_q.size() != 0) m_drain = 1;
        else m_pkt = 0;
      end
      if (clear_stats_i) for (int i = 0; i < 5; i++) m_cnt[i] = 0;
      if (in_acc) begin
        if (m_cnt[0] < 15) m_cnt[0]++;
        for (int b = 0; b < 4; b++)
          if (data_i[31-b] && m_cnt[b+1] < 15) m_cnt[b+1]++;
      end
      in_acc_seen = in_acc;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [RW-1:0] w);
    bit done;
    done = 0;
    data_i  = w;
    valid_i = 1'b1;
    for (int k = 0; k < 64; k++) begin
      cyc();
      if (in_acc_seen) begin done = 1; break; end
    end
    if (!done) check("send_timeout", 0, 1);
    valid_i = 1'b0;
  endtask

  task automatic drain_all();
    for (int k = 0; k < 100; k++) begin
      if (sb_q.size() == 0) break;
      cyc();
    end
    if (sb_q.size() != 0) check("drain_timeout", 64'(sb_q.size()), 0);
    cyc();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    out_idx = 0;
    last_mask = '0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_m_valid"}, 64'(m_valid_o), 0);
    check({tag, "_m_last"},  64'(m_last_o), 0);
    check({tag, "_level"},   64'(fifo_level_o), 0);
    check({tag, "_ready"},   64'(ready_o), 1);
    check({tag, "_cnt_total"}, 64'(cnt_total_o), 0);
    check({tag, "_cnt_key"},   64'(cnt_key_present_o), 0);
    check({tag, "_cnt_nd"},    64'(cnt_no_del_o), 0);
  endtask

  initial begin
    reset = 1'b1; data_i = '0; valid_i = 1'b0; m_ready_i = 1'b0;
    flush_i = 1'b0; clear_stats_i = 1'b0;
    out_idx = 0; last_mask = '0;

    do_reset();
    check_reset_state("rst");

    // Basic pass-through and status counting.
    m_ready_i = 1'b1;
    send(32'h8000_0005);
    send(32'h4000_0000);
    send(32'h1FFF_C00A);
    drain_all();
    check("basic_total", 64'(cnt_total_o), 3);
    check("basic_key",   64'(cnt_key_present_o), 1);
    check("basic_nf",    64'(cnt_not_found_o), 1);
    check("basic_ns",    64'(cnt_no_space_o), 0);
    check("basic_nd",    64'(cnt_no_del_o), 1);
    check("basic_nolast", 64'(last_mask), 0);

    // Fill to full with the host stalled; pointers wrap past entry 15.
    m_ready_i = 1'b0;
    for (int i = 0; i < 16; i++) send(32'h0100_0000 + 32'(i));
    data_i = 32'h0ABC_0010;
    valid_i = 1'b1;
    cyc();
    cyc();
    check("full_ready", 64'(ready_o), 0);
    check("full_level", 64'(fifo_level_o), 16);
    check("full_held",  64'(in_acc_seen), 0);
    m_ready_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cyc();
      if (in_acc_seen) break;
    end
    check("full_17th_accepted", 64'(in_acc_seen), 1);
    valid_i = 1'b0;
    drain_all();
    check("full_lastmask", 64'(last_mask), 64'(32'h0000_8080));

    // Packet framing over 24 words.
    do_reset();
    m_ready_i = 1'b1;
    for (int i = 0; i < 24; i++) send(32'(i) | ((i % 3 == 0) ? 32'h2000_0000 : 32'h0));
    drain_all();
    check("pkt_lastmask", 64'(last_mask), 64'(32'h0080_8080));

    // Flush closes a partial packet early.
    do_reset();
    m_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) send(32'h0000_0100 + 32'(i));
    drain_all();
    m_ready_i = 1'b0;
    send(32'h0000_0200);
    send(32'h0000_0201);
    flush_i = 1'b1;
    cyc();
    flush_i = 1'b0;
    check("flush_ready_low", 64'(ready_o), 0);
    cyc();
    check("flush_still_low", 64'(ready_o), 0);
    m_ready_i = 1'b1;
    drain_all();
    check("flush_ready_back", 64'(ready_o), 1);
    for (int i = 0; i < 8; i++) send(32'h0000_0300 + 32'(i));
    drain_all();
    for (int i = 0; i < 2; i++) send(32'h0000_0400 + 32'(i));
    drain_all();
    flush_i = 1'b1;
    cyc();
    flush_i = 1'b0;
    check("flush_empty_novalid", 64'(m_valid_o), 0);
    check("flush_empty_ready", 64'(ready_o), 1);
    for (int i = 0; i < 8; i++) send(32'h0000_0500 + 32'(i));
    drain_all();
    check("flush_lastmask", 64'(last_mask), 64'(32'h0040_1010));

    // Counter saturation and clear-with-accept.
    do_reset();
    m_ready_i = 1'b1;
    for (int i = 0; i < 17; i++) send(32'h8000_0000 | 32'(i));
    drain_all();
    check("sat_key",   64'(cnt_key_present_o), 15);
    check("sat_total", 64'(cnt_total_o), 15);
    clear_stats_i = 1'b1;
    send(32'h8000_0000);
    clear_stats_i = 1'b0;
    cyc();
    check("clr_total", 64'(cnt_total_o), 1);
    check("clr_key",   64'(cnt_key_present_o), 1);
    check("clr_nf",    64'(cnt_not_found_o), 0);
    drain_all();

    // Reset while draining.
    m_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) send(32'hF000_0000 | 32'(i));
    flush_i = 1'b1;
    cyc();
    flush_i = 1'b0;
    check("pre_rst_drain_ready", 64'(ready_o), 0);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check_reset_state("mid_rst");
    cyc();
    cyc();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
